// File: rtl/usb_tx_serializer.sv
// Byte-to-line USB transmitter: LSB-first shift, bit stuffing after six ones, NRZI, SE0-SE0-J EOP.
// First bit on the line one cycle after the load edge; loads and EOP requests are accepted only when not busy.
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       piso_loading,
    input  logic [7:0] piso_data,
    input  logic       eop_req,
    output logic       piso_busy,
    output logic       piso_done,
    output logic       stuffer_done,
    output logic       eop_done,
    output logic       tx_dp,
    output logic       tx_dm,
    output logic       tx_oe
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic LVL_J = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        STUFF,
        READY,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic [2:0]       ones_cnt, ones_cnt_n;
    logic             lvl, lvl_n;
    logic [7:0]       shreg, shreg_n;

    logic             busy_n;
    logic             piso_done_n;
    logic             stuffer_done_n;
    logic             eop_done_n;
    logic             tx_dp_n;
    logic             tx_dm_n;
    logic             tx_oe_n;

    logic             load_ok;
    logic             bit_end;
    logic             cur_bit;
    logic [2:0]       nxt_idx;
    logic [2:0]       ones_upd;

    // piso_done blocks a reload for one cycle so tx_fsm sees the pulse before re-arming
    assign load_ok  = piso_loading && !piso_busy && !piso_done;
    assign bit_end  = (bit_cnt == CNT_LAST);
    assign cur_bit  = shreg[bit_idx[2:0]];
    assign nxt_idx  = bit_idx[2:0] + 3'd1;
    assign ones_upd = cur_bit ? (ones_cnt + 3'd1) : 3'd0;

    always_comb begin
        state_n        = state;
        bit_cnt_n      = bit_cnt;
        bit_idx_n      = bit_idx;
        ones_cnt_n     = ones_cnt;
        lvl_n          = lvl;
        shreg_n        = shreg;
        piso_done_n    = 1'b0;
        stuffer_done_n = 1'b0;
        eop_done_n     = 1'b0;

        case (state)
            IDLE: begin
                ones_cnt_n = 3'd0;
                lvl_n      = LVL_J;
                if (load_ok) begin
                    state_n   = DATA;
                    shreg_n   = piso_data;
                    bit_idx_n = 4'd0;
                    bit_cnt_n = '0;
                    lvl_n     = piso_data[0] ? LVL_J : ~LVL_J;
                end
            end

            DATA: begin
                bit_cnt_n = bit_end ? '0 : bit_cnt + CNT_W'(1);
                if (bit_end) begin
                    ones_cnt_n = ones_upd;
                    if (ones_upd == 3'd6) begin
                        state_n   = STUFF;
                        bit_idx_n = bit_idx + 4'd1;
                        lvl_n     = ~lvl;
                    end else if (bit_idx[2:0] == 3'd7) begin
                        state_n     = READY;
                        piso_done_n = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                        lvl_n     = shreg[nxt_idx] ? lvl : ~lvl;
                    end
                end
            end

            STUFF: begin
                bit_cnt_n = bit_end ? '0 : bit_cnt + CNT_W'(1);
                if (bit_end) begin
                    ones_cnt_n     = 3'd0;
                    stuffer_done_n = 1'b1;
                    // bit_idx == 8 means the stuff bit followed the last data bit
                    if (bit_idx == 4'd8) begin
                        state_n     = READY;
                        piso_done_n = 1'b1;
                    end else begin
                        state_n = DATA;
                        lvl_n   = cur_bit ? lvl : ~lvl;
                    end
                end
            end

            READY: begin
                if (load_ok) begin
                    state_n   = DATA;
                    shreg_n   = piso_data;
                    bit_idx_n = 4'd0;
                    bit_cnt_n = '0;
                    lvl_n     = piso_data[0] ? lvl : ~lvl;
                end else if (eop_req) begin
                    state_n   = EOP_SE0;
                    bit_idx_n = 4'd0;
                    bit_cnt_n = '0;
                end
            end

            EOP_SE0: begin
                bit_cnt_n = bit_end ? '0 : bit_cnt + CNT_W'(1);
                if (bit_end) begin
                    if (bit_idx == 4'd1) begin
                        state_n   = EOP_J;
                        bit_idx_n = 4'd0;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end

            EOP_J: begin
                bit_cnt_n = bit_end ? '0 : bit_cnt + CNT_W'(1);
                if (bit_end) begin
                    state_n    = IDLE;
                    lvl_n      = LVL_J;
                    ones_cnt_n = 3'd0;
                    eop_done_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                lvl_n   = LVL_J;
            end
        endcase

        // Line outputs follow the next state so every output is a plain register
        tx_oe_n = 1'b1;
        case (state_n)
            IDLE: begin
                tx_dp_n = 1'b1;
                tx_dm_n = 1'b0;
                tx_oe_n = 1'b0;
            end
            EOP_SE0: begin
                tx_dp_n = 1'b0;
                tx_dm_n = 1'b0;
            end
            EOP_J: begin
                tx_dp_n = 1'b1;
                tx_dm_n = 1'b0;
            end
            default: begin
                tx_dp_n = lvl_n;
                tx_dm_n = ~lvl_n;
            end
        endcase

        busy_n = (state_n == DATA) || (state_n == STUFF) ||
                 (state_n == EOP_SE0) || (state_n == EOP_J);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= 4'd0;
            ones_cnt     <= 3'd0;
            lvl          <= LVL_J;
            shreg        <= 8'd0;
            piso_busy    <= 1'b0;
            piso_done    <= 1'b0;
            stuffer_done <= 1'b0;
            eop_done     <= 1'b0;
            tx_dp        <= 1'b1;
            tx_dm        <= 1'b0;
            tx_oe        <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            bit_idx      <= bit_idx_n;
            ones_cnt     <= ones_cnt_n;
            lvl          <= lvl_n;
            shreg        <= shreg_n;
            piso_busy    <= busy_n;
            piso_done    <= piso_done_n;
            stuffer_done <= stuffer_done_n;
            eop_done     <= eop_done_n;
            tx_dp        <= tx_dp_n;
            tx_dm        <= tx_dm_n;
            tx_oe        <= tx_oe_n;
        end
    end

endmodule
